// File: rtl/if_fetch.sv
// if_fetch: instruction fetch stage with imem req/ack handshake, stall hold buffer and flush drain
module if_fetch #(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [XLEN-1:0] pc_i,
    output logic            pc_en_o,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_ack_i,
    input  logic [XLEN-1:0] imem_rdata_i,
    input  logic            id_stall_i,
    input  logic            flush_i,
    output logic            if_valid_o,
    output logic [XLEN-1:0] if_pc_o,
    output logic [XLEN-1:0] if_instr_o
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, DRAIN} state_t;
    state_t state, state_n;
    logic [XLEN-1:0] addr_q, hold_pc, hold_instr;
    logic hold_v, slot_free, in_req, take, load_req, load_hold, hold_clr;
    assign slot_free = !if_valid_o || !id_stall_i;
    assign in_req    = state == REQ;
    assign take      = in_req && imem_ack_i && !flush_i;
    assign load_req  = take && slot_free;
    assign load_hold = state == WAIT && !id_stall_i && hold_v;
    assign hold_clr  = state == WAIT && (!id_stall_i || flush_i);
    always_ff @(posedge clk_i or posedge rst_i)
        if (rst_i)
            state <= IDLE;
        else
            state <= state_n;
    always_comb
        state_n = state == IDLE ? REQ :
                  state == REQ  ? (flush_i ? (imem_ack_i ? REQ : DRAIN) :
                                  (imem_ack_i && !slot_free ? WAIT : REQ)) :
                  state == WAIT ? ((!id_stall_i || flush_i) ? REQ : WAIT) :
                                  (imem_ack_i ? REQ : DRAIN);
    always_comb begin
        imem_req_o  = in_req || state == DRAIN;
        imem_addr_o = in_req ? pc_i : state == DRAIN ? addr_q : '0;
        pc_en_o     = take;
    end
    always_ff @(posedge clk_i or posedge rst_i)
        if (rst_i) begin
            addr_q     <= '0;
            hold_v     <= 1'b0;
            hold_pc    <= '0;
            hold_instr <= '0;
            if_valid_o <= 1'b0;
            if_pc_o    <= '0;
            if_instr_o <= '0;
        end else begin
            if (in_req)
                addr_q <= pc_i;
            if (take && !slot_free) begin
                hold_v     <= 1'b1;
                hold_pc    <= pc_i;
                hold_instr <= imem_rdata_i;
            end else if (hold_clr)
                hold_v <= 1'b0;
            if (flush_i)
                if_valid_o <= 1'b0;
            else if (load_req) begin
                if_valid_o <= 1'b1;
                if_pc_o    <= pc_i;
                if_instr_o <= imem_rdata_i;
            end else if (load_hold) begin
                if_valid_o <= 1'b1;
                if_pc_o    <= hold_pc;
                if_instr_o <= hold_instr;
            end else if (!id_stall_i)
                if_valid_o <= 1'b0;
        end
endmodule

// File: tb/tb_if_fetch.sv
// tb_if_fetch: directed stimulus with a PC register and memory model; consumed IF/ID entries are scoreboarded
module tb_if_fetch;
    localparam logic [31:0] K = 32'hA5A5A5A5;
    logic        clk = 1'b0, rst = 1'b1;
    logic [31:0] pc, addr, rdata, if_pc, if_instr, redir = '0;
    logic        pc_en, req, ack, stall = 1'b0, flush = 1'b0, if_valid;
    logic        mem_en = 1'b1;
    int          ws = 0, wcnt;
    int          passed = 0, total = 0;
    logic [31:0] q[$];

    if_fetch #(.XLEN(32)) dut (
        .clk_i(clk), .rst_i(rst), .pc_i(pc), .pc_en_o(pc_en),
        .imem_req_o(req), .imem_addr_o(addr), .imem_ack_i(ack), .imem_rdata_i(rdata),
        .id_stall_i(stall), .flush_i(flush),
        .if_valid_o(if_valid), .if_pc_o(if_pc), .if_instr_o(if_instr)
    );

    always #5 clk = ~clk;

    assign ack   = mem_en && req && (wcnt >= ws);
    assign rdata = addr ^ K;

    always @(posedge clk or posedge rst)
        if (rst) wcnt <= 0;
        else wcnt <= (req && mem_en && !ack) ? wcnt + 1 : 0;

    always @(posedge clk or posedge rst)
        if (rst) pc <= '0;
        else if (flush) pc <= redir;
        else if (pc_en) pc <= pc + 32'd4;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        else passed++;
    endtask

    task automatic nxt;
        @(posedge clk);
        #1;
    endtask

    initial forever begin
        @(negedge clk);
        if (!rst && if_valid && !stall && !flush) begin
            if (q.size() == 0) begin
                total++;
                $display("FAIL sb_unexpected: got pc %h with empty queue at %0t", if_pc, $time);
            end else begin
                logic [31:0] e;
                e = q.pop_front();
                chk("sb_pc", if_pc, e);
                chk("sb_instr", if_instr, e ^ K);
            end
        end
    end

    initial begin
        #2;
        chk("rst_req", req, 0);
        chk("rst_addr", addr, 0);
        chk("rst_pc_en", pc_en, 0);
        chk("rst_valid", if_valid, 0);
        chk("rst_if_pc", if_pc, 0);
        chk("rst_if_instr", if_instr, 0);
        #4 rst = 1'b0;
        @(negedge clk);
        chk("idle_req", req, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("zw_req", req, 1);
            chk("zw_addr", addr, 32'(4 * i));
            chk("zw_pc_en", pc_en, 1);
            q.push_back(32'(4 * i));
        end
        nxt();
        ws = 2;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("ws_req", req, 1);
            chk("ws_addr", addr, 32'h10);
            chk("ws_pc_en", pc_en, (i == 2) ? 32'd1 : 32'd0);
            if (i == 2) q.push_back(32'h10);
        end
        nxt();
        ws = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i == 0) chk("ws_if_pc", if_pc, 32'h10);
            chk("st_pre_addr", addr, 32'(32'h14 + 4 * i));
            chk("st_pre_pc_en", pc_en, 1);
            q.push_back(32'(32'h14 + 4 * i));
        end
        nxt();
        stall = 1'b1;
        @(negedge clk);
        chk("st_ack_addr", addr, 32'h24);
        chk("st_ack_pc_en", pc_en, 1);
        chk("st_ack_if_pc", if_pc, 32'h20);
        q.push_back(32'h24);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("st_wait_req", req, 0);
            chk("st_wait_pc_en", pc_en, 0);
            chk("st_wait_if_pc", if_pc, 32'h20);
            chk("st_wait_valid", if_valid, 1);
        end
        nxt();
        stall = 1'b0;
        @(negedge clk);
        chk("st_rel_req", req, 0);
        @(negedge clk);
        chk("st_rel_if_pc", if_pc, 32'h24);
        chk("st_rel_addr", addr, 32'h28);
        chk("st_rel_pc_en", pc_en, 1);
        q.push_back(32'h28);
        @(negedge clk);
        chk("st_next_addr", addr, 32'h2C);
        q.push_back(32'h2C);
        nxt();
        mem_en = 1'b0;
        @(negedge clk);
        chk("fl_out_addr", addr, 32'h30);
        chk("fl_out_pc_en", pc_en, 0);
        nxt();
        flush = 1'b1;
        redir = 32'h100;
        @(negedge clk);
        chk("fl_pc_en", pc_en, 0);
        chk("fl_addr", addr, 32'h30);
        nxt();
        flush = 1'b0;
        @(negedge clk);
        chk("dr_req", req, 1);
        chk("dr_addr", addr, 32'h30);
        chk("dr_valid", if_valid, 0);
        chk("dr_pc_en", pc_en, 0);
        nxt();
        mem_en = 1'b1;
        @(negedge clk);
        chk("dr_ack_addr", addr, 32'h30);
        chk("dr_ack_pc_en", pc_en, 0);
        @(negedge clk);
        chk("rd_valid", if_valid, 0);
        chk("rd_addr", addr, 32'h100);
        chk("rd_pc_en", pc_en, 1);
        q.push_back(32'h100);
        nxt();
        mem_en = 1'b0;
        @(negedge clk);
        chk("rd_if_pc", if_pc, 32'h100);
        chk("rd_if_valid", if_valid, 1);
        nxt();
        flush = 1'b1;
        redir = 32'h40;
        nxt();
        flush = 1'b0;
        mem_en = 1'b1;
        nxt();
        flush = 1'b1;
        redir = 32'h200;
        @(negedge clk);
        chk("fa_addr", addr, 32'h40);
        chk("fa_req", req, 1);
        chk("fa_pc_en", pc_en, 0);
        nxt();
        flush = 1'b0;
        @(negedge clk);
        chk("fa_valid", if_valid, 0);
        chk("fa_next_addr", addr, 32'h200);
        chk("fa_next_pc_en", pc_en, 1);
        nxt();
        stall = 1'b1;
        @(negedge clk);
        chk("ar_if_pc", if_pc, 32'h200);
        chk("ar_if_valid", if_valid, 1);
        @(negedge clk);
        chk("ar_wait_req", req, 0);
        chk("ar_wait_pc_en", pc_en, 0);
        #3 rst = 1'b1;
        #1;
        chk("ar_req", req, 0);
        chk("ar_addr", addr, 0);
        chk("ar_pc_en", pc_en, 0);
        chk("ar_valid", if_valid, 0);
        chk("ar_if_pc0", if_pc, 0);
        chk("ar_if_instr", if_instr, 0);
        nxt();
        rst = 1'b0;
        stall = 1'b0;
        mem_en = 1'b0;
        @(negedge clk);
        chk("ar_idle_req", req, 0);
        chk("ar_idle_valid", if_valid, 0);
        @(negedge clk);
        chk("ar_req1", req, 1);
        chk("ar_addr1", addr, 0);
        chk("ar_hold_gone", if_valid, 0);
        nxt();
        mem_en = 1'b1;
        @(negedge clk);
        chk("ar_pc_en1", pc_en, 1);
        q.push_back(32'h0);
        nxt();
        mem_en = 1'b0;
        @(negedge clk);
        chk("ar_if_pc1", if_pc, 0);
        chk("ar_if_valid1", if_valid, 1);
        @(negedge clk);
        chk("sb_drained", 32'(q.size()), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
